fifo_port_ctrl: RTL and testbench
=================================

Name: fifo_port_ctrl

Overview:
- Controller that shares one 8-bit synchronous FIFO between N_REQ write requesters using round-robin arbitration.
- Drains the FIFO into a single downstream consumer over a valid/ready handshake.
- Generates the FIFO's single-cycle wr/rd strobes and owns its data_in bus.
- Sits between producer blocks (keyboard/UART/game logic) and the FIFO instance.

Parameters:
- N_REQ, 4, number of write requesters (2..8).
- DW, 8, data width; must match the FIFO data width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester write request, level.
- wdata  in  N_REQ*DW  packed requester data; requester i at bits [i*DW +: DW].
- gnt  out  N_REQ  one-hot grant pulse, high in the cycle the write is issued.
- fifo_wr  out  1  FIFO write strobe (single-cycle pulse).
- fifo_data_in  out  DW  data presented to FIFO, valid while fifo_wr=1.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  FIFO read strobe (single-cycle pulse).
- fifo_data_out  in  DW  FIFO read data, valid in the cycle after fifo_rd=1.
- dout  out  DW  data to consumer.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout when high together with dout_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - gnt=0, fifo_wr=0, fifo_data_in=0, fifo_rd=0, dout=0, dout_valid=0.
  - RR pointer=0; write FSM to W_IDLE; read FSM to R_IDLE.
  - Any in-flight write or read is abandoned. The FIFO's own reset clears its contents.
- Write arbiter, states W_IDLE and W_ISSUE:
  - W_IDLE: if |req and !fifo_full, pick the first asserted req index scanning ptr, ptr+1, … mod N_REQ. Register fifo_wr=1, the winner's gnt bit, and fifo_data_in=wdata[winner]. Set ptr=(winner+1) mod N_REQ and go to W_ISSUE.
  - W_ISSUE (exactly one cycle): fifo_wr and gnt are high. Clear them at the next edge and return to W_IDLE; req is not sampled here.
  - Result: at most one write per 2 cycles. This guarantees fifo_full has updated before the next decision, so the FIFO is never overfilled.
  - Latency: req sampled high at edge k gives fifo_wr/gnt high for the cycle after edge k.
  - Requester contract: hold req and wdata stable until gnt is seen. Drop or update req in the gnt cycle; if req is still high after gnt, that is a new request.
  - fifo_full=1 in W_IDLE: no grant, requests stay pending, ptr unchanged.
  - Data is registered at decision time; later wdata changes do not affect the issued write.
- Read sequencer, states R_IDLE, R_ISSUE, R_CAPT, R_HOLD:
  - R_IDLE: if !fifo_empty and dout_valid=0, set fifo_rd=1 and go to R_ISSUE.
  - R_ISSUE: fifo_rd high one cycle; clear it and go to R_CAPT.
  - R_CAPT: dout<=fifo_data_out, dout_valid<=1, go to R_HOLD.
  - R_HOLD: dout and dout_valid are held. On dout_valid&&dout_ready, clear dout_valid at that edge and go to R_IDLE.
  - Latency: with the FIFO non-empty, dout_valid rises 3 edges after R_IDLE sees !fifo_empty. Minimum 4 cycles per word.
  - dout_ready high while dout_valid=0 is ignored.
  - fifo_empty rising while in R_ISSUE/R_CAPT does not abort; the word is captured.
- Write and read paths are independent; simultaneous fifo_wr and fifo_rd are allowed (the FIFO supports it).
- A single fifo_rd is never issued while a word is held; no underflow strobes are generated when fifo_empty=1.

Test Plan:
- Reset: drive reset=0 mid-operation with dout_valid=1 and fifo_wr=1 → all outputs 0 immediately, without a clock edge. Release reset; first grant goes to req[0].
- Single write: req=0001, wdata[7:0]=0x68, fifo_full=0 → the cycle after sampling, fifo_wr=1, fifo_data_in=0x68, gnt=0001, for exactly one cycle.
- Round-robin: req=1111 with data 0x61/0x62/0x63/0x64, each requester dropping req after its gnt → gnt order 0001, 0010, 0100, 1000 on alternate cycles, data 0x61..0x64. Then req=0001 again → granted (ptr wrapped to 0).
- Full back-pressure: fifo_full=1, req=0100 for 10 cycles → no fifo_wr/gnt. Deassert fifo_full → gnt=0100 within 2 cycles.
- Drain with stall: fifo_empty=0, fifo_data_out=0x6F, dout_ready=0 → one fifo_rd pulse, then dout=0x6F with dout_valid=1 held with no further fifo_rd. Set dout_ready=1 → dout_valid drops next edge and the next fifo_rd follows.
- Concurrent: writes from req[1] every 2 cycles while draining with dout_ready=1 → every written byte appears on dout in FIFO order; no lost or duplicated strobes.

Source files
------------

// File: rtl/fifo_port_ctrl.sv
// fifo_port_ctrl: round-robin write arbitration of N_REQ requesters into a shared FIFO,
// plus a read sequencer that drains it to one consumer over valid/ready.
module fifo_port_ctrl #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_REQ-1:0]  req_i,
  input  logic [N_REQ*DW-1:0] wdata_i,
  output logic [N_REQ-1:0]  gnt_o,
  output logic              fifo_wr_o,
  output logic [DW-1:0]     fifo_data_in_o,
  input  logic              fifo_full_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_o,
  input  logic [DW-1:0]     fifo_data_out_i,
  output logic [DW-1:0]     dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW:0]   NR   = (PW+1)'(N_REQ);
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

  typedef enum logic {W_IDLE, W_ISSUE} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_CAPT, R_HOLD} r_state_e;

  w_state_e            w_state_q, w_state_d;
  r_state_e            r_state_q, r_state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic [DW-1:0]       wdat_q, wdat_d;
  logic                rd_q, rd_d;
  logic [DW-1:0]       dout_q, dout_d;
  logic                dv_q, dv_d;

  logic [2*N_REQ-1:0]  req_dbl;
  logic [N_REQ-1:0]    req_rot;
  logic                win_vld;
  logic [PW-1:0]       win_off, win_idx;
  logic [PW:0]         win_sum;
  logic [N_REQ-1:0]    win_gnt;
  logic [DW-1:0]       win_data;

  // Rotate requests so bit 0 is the requester the pointer currently favours.
  assign req_dbl = {req_i, req_i} >> ptr_q;
  assign req_rot = req_dbl[N_REQ-1:0];

  always_comb begin
    win_vld = 1'b0;
    win_off = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_vld = 1'b1;
        win_off = PW'(i);
      end
    end
  end

  assign win_sum = {1'b0, ptr_q} + {1'b0, win_off};
  assign win_idx = (win_sum >= NR) ? PW'(win_sum - NR) : PW'(win_sum);

  always_comb begin
    win_gnt  = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_gnt[i] = (win_idx == PW'(i));
      if (win_idx == PW'(i)) win_data = wdata_i[i*DW +: DW];
    end
  end

  // Issuing for exactly one cycle lets fifo_full settle before the next decision.
  always_comb begin
    w_state_d = w_state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    wdat_d    = wdat_q;
    if (w_state_q == W_IDLE) begin
      if (win_vld && !fifo_full_i) begin
        w_state_d = W_ISSUE;
        gnt_d     = win_gnt;
        wr_d      = 1'b1;
        wdat_d    = win_data;
        ptr_d     = (win_idx == LAST) ? '0 : win_idx + PW'(1);
      end
    end else begin
      w_state_d = W_IDLE;
      gnt_d     = '0;
      wr_d      = 1'b0;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rd_d      = 1'b0;
    dout_d    = dout_q;
    dv_d      = dv_q;
    case (r_state_q)
      R_IDLE: begin
        if (!fifo_empty_i && !dv_q) begin
          rd_d      = 1'b1;
          r_state_d = R_ISSUE;
        end
      end
      R_ISSUE: r_state_d = R_CAPT;
      R_CAPT: begin
        dout_d    = fifo_data_out_i;
        dv_d      = 1'b1;
        r_state_d = R_HOLD;
      end
      R_HOLD: begin
        if (dv_q && dout_ready_i) begin
          dv_d      = 1'b0;
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      wr_q      <= 1'b0;
      wdat_q    <= '0;
      rd_q      <= 1'b0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      wdat_q    <= wdat_d;
      rd_q      <= rd_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
    end
  end

  assign gnt_o          = gnt_q;
  assign fifo_wr_o      = wr_q;
  assign fifo_data_in_o = wdat_q;
  assign fifo_rd_o      = rd_q;
  assign dout_o         = dout_q;
  assign dout_valid_o   = dv_q;
endmodule

// File: tb/tb_fifo_port_ctrl.sv
// tb_fifo_port_ctrl: directed vectors for arbitration plus hand sequences for the
// read handshake, async reset, and a concurrent run against a small FIFO model.
module tb_fifo_port_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] wdata = '0;
  logic        full_drv = 1'b0, empty_drv = 1'b1, dout_ready = 1'b0, use_model = 1'b0;
  logic [7:0]  data_drv = '0;
  logic [3:0]  gnt;
  logic        fifo_wr, fifo_rd, dout_valid, fifo_full, fifo_empty;
  logic [7:0]  fifo_data_in, fifo_data_out, dout;
  logic        m_full = 1'b0, m_empty = 1'b1;
  logic [7:0]  m_data = '0;
  logic [7:0]  mq[$];
  int          m_under = 0, m_over = 0;
  int          n_chk = 0, n_fail = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        full;
    logic [3:0]  gnt;
    logic        wr;
    logic [7:0]  d;
  } vec_t;
  vec_t tbl[17];
  logic [7:0] bl[8];

  assign fifo_full     = use_model ? m_full  : full_drv;
  assign fifo_empty    = use_model ? m_empty : empty_drv;
  assign fifo_data_out = use_model ? m_data  : data_drv;

  fifo_port_ctrl #(.N_REQ(4), .DW(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wdata_i(wdata), .gnt_o(gnt),
    .fifo_wr_o(fifo_wr), .fifo_data_in_o(fifo_data_in), .fifo_full_i(fifo_full),
    .fifo_empty_i(fifo_empty), .fifo_rd_o(fifo_rd), .fifo_data_out_i(fifo_data_out),
    .dout_o(dout), .dout_valid_o(dout_valid), .dout_ready_i(dout_ready)
  );

  always #5 clk = ~clk;

  // Depth-4 FIFO model: flags and read data update after the edge like real storage.
  always @(posedge clk) begin
    if (use_model) begin
      if (fifo_rd) begin
        if (mq.size() == 0) m_under++;
        else m_data <= mq.pop_front();
      end
      if (fifo_wr) begin
        if (mq.size() >= 4) m_over++;
        else mq.push_back(fifo_data_in);
      end
      m_full  <= (mq.size() >= 4);
      m_empty <= (mq.size() == 0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int k, wi, wr_cnt, rd_cnt;
    bit got;
    tbl[0]  = '{4'b0001, 32'h0000_0068, 1'b0, 4'b0001, 1'b1, 8'h68};
    tbl[1]  = '{4'b0000, 32'h0000_0068, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[2]  = '{4'b1111, 32'h6463_6261, 1'b0, 4'b0010, 1'b1, 8'h62};
    tbl[3]  = '{4'b1101, 32'h6463_6261, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[4]  = '{4'b1101, 32'h6463_6261, 1'b0, 4'b0100, 1'b1, 8'h63};
    tbl[5]  = '{4'b1001, 32'h6463_6261, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[6]  = '{4'b1001, 32'h6463_6261, 1'b0, 4'b1000, 1'b1, 8'h64};
    tbl[7]  = '{4'b0001, 32'h6463_6261, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[8]  = '{4'b0001, 32'h6463_6261, 1'b0, 4'b0001, 1'b1, 8'h61};
    tbl[9]  = '{4'b0000, 32'h6463_6261, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[10] = '{4'b0001, 32'h6463_6261, 1'b0, 4'b0001, 1'b1, 8'h61};
    tbl[11] = '{4'b0000, 32'h0000_0099, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[12] = '{4'b0010, 32'h0000_4100, 1'b0, 4'b0010, 1'b1, 8'h41};
    tbl[13] = '{4'b0000, 32'h0000_5500, 1'b0, 4'b0000, 1'b0, 8'h00};
    tbl[14] = '{4'b0100, 32'h0077_0000, 1'b1, 4'b0000, 1'b0, 8'h00};
    tbl[15] = '{4'b0100, 32'h0077_0000, 1'b0, 4'b0100, 1'b1, 8'h77};
    tbl[16] = '{4'b0000, 32'h0077_0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    bl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};

    #2 rst_n = 1'b0;
    #1 check("async reset outputs", {gnt, fifo_wr, fifo_data_in, fifo_rd, dout, dout_valid}, 0);
    tick;
    tick;
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      req = tbl[i].req;
      wdata = tbl[i].wdata;
      full_drv = tbl[i].full;
      tick;
      check($sformatf("row%0d gnt", i), gnt, tbl[i].gnt);
      check($sformatf("row%0d wr", i), fifo_wr, tbl[i].wr);
      if (tbl[i].wr) check($sformatf("row%0d data", i), fifo_data_in, tbl[i].d);
      check($sformatf("row%0d rd", i), fifo_rd, 0);
    end

    // Back-pressure holds the pointer (now 3) for 10 cycles.
    full_drv = 1'b1;
    req = 4'b1111;
    wdata = 32'h4433_2211;
    for (int c = 0; c < 10; c++) begin
      tick;
      check($sformatf("full hold %0d", c), {gnt, fifo_wr}, 0);
    end
    full_drv = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 2 && !got; c++) begin
      tick;
      if (gnt != 0) got = 1'b1;
    end
    check("grant after full", got, 1);
    check("gnt after full", gnt, 4'b1000);
    check("data after full", fifo_data_in, 8'h44);
    req = 4'b0000;
    tick;

    // Drain with a stalled consumer.
    empty_drv = 1'b0;
    data_drv = 8'h6F;
    tick;
    check("drain rd pulse", {fifo_rd, dout_valid}, 2'b10);
    tick;
    check("drain rd cleared", fifo_rd, 0);
    tick;
    check("drain dv", dout_valid, 1);
    check("drain dout", dout, 8'h6F);
    for (int c = 0; c < 5; c++) begin
      tick;
      check($sformatf("stall hold %0d", c), {dout_valid, fifo_rd, dout}, {2'b10, 8'h6F});
    end
    dout_ready = 1'b1;
    tick;
    check("accept drops dv", {dout_valid, fifo_rd}, 2'b00);
    tick;
    check("next rd", fifo_rd, 1);
    empty_drv = 1'b1;
    data_drv = 8'h70;
    tick;
    check("issue no dv", {dout_valid, fifo_rd}, 2'b00);
    tick;
    check("capture despite empty", {dout_valid, dout}, {1'b1, 8'h70});
    tick;
    check("second accept", dout_valid, 0);
    for (int c = 0; c < 3; c++) begin
      tick;
      check($sformatf("no underflow rd %0d", c), fifo_rd, 0);
    end

    // Reset while a word is held and a write is in flight.
    dout_ready = 1'b0;
    empty_drv = 1'b0;
    data_drv = 8'h5A;
    tick;
    tick;
    tick;
    req = 4'b0001;
    wdata = 32'h0000_0011;
    tick;
    check("pre-reset wr/dv", {fifo_wr, dout_valid}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("mid-op reset outputs", {gnt, fifo_wr, fifo_data_in, fifo_rd, dout, dout_valid}, 0);
    req = 4'b1111;
    empty_drv = 1'b1;
    #2 rst_n = 1'b1;
    tick;
    check("first grant after reset", gnt, 4'b0001);
    req = 4'b0000;
    tick;

    // Concurrent writes from requester 1 while draining through the FIFO model.
    use_model = 1'b1;
    dout_ready = 1'b1;
    k = 0; wi = 0; wr_cnt = 0; rd_cnt = 0;
    req = 4'b0010;
    wdata = {16'h0, bl[0], 8'h0};
    for (int c = 0; c < 300 && k < 8; c++) begin
      tick;
      if (fifo_wr) wr_cnt++;
      if (fifo_rd) rd_cnt++;
      if (gnt[1]) begin
        wi++;
        if (wi < 8) wdata = {16'h0, bl[wi], 8'h0};
        else req = 4'b0000;
      end
      if (dout_valid && dout_ready) begin
        check($sformatf("concurrent word %0d", k), dout, bl[k]);
        k++;
      end
    end
    check("concurrent words seen", k, 8);
    check("concurrent wr count", wr_cnt, 8);
    check("concurrent rd count", rd_cnt, 8);
    check("model underflow", m_under, 0);
    check("model overflow", m_over, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
